// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file.
//   NR registered read ports (latency 1) and NW write ports. When several
//   write ports target the same address, the highest port index wins.
//   Optional same-cycle write-to-read bypass (BYPASS) and optional
//   hard-wired zero entry 0 (ZERO_REG). A clear engine zeroes one entry per
//   cycle for N cycles while busy is high. Reads, writes and clear requests
//   are ignored while busy is high.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   R_addr/R_en       per-read-port address slices and enables
//   R_data/R_valid    registered read data (held when idle) and strobe
//   W_addr/W_en/W_data per-write-port address, enable and data slices
//   clear             single-cycle request to zero all entries
//   busy              high while the clear engine is running
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int N        = 32,
  parameter int NR       = 2,
  parameter int NW       = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NR*ADDR_W-1:0] R_addr,
  input  logic [NR-1:0]        R_en,
  output logic [NR*WIDTH-1:0]  R_data,
  output logic [NR-1:0]        R_valid,
  input  logic [NW*ADDR_W-1:0] W_addr,
  input  logic [NW-1:0]        W_en,
  input  logic [NW*WIDTH-1:0]  W_data,
  input  logic                 clear,
  output logic                 busy
);

  // Address space is rounded up to a power of two; entries at or above N
  // are tied to zero so any address can index the array safely.
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   N_EXT = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic              idle;
  logic [WIDTH-1:0]  mem [DEPTH];

  assign idle = (state_reg == IDLE);
  assign busy = (state_reg == CLEAR);

  // Clear engine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (clear) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      CLEAR: begin
        // ptr stops at N-1; it is re-zeroed on the next clear request.
        if (ptr_reg == LAST) begin
          state_next = IDLE;
        end else begin
          ptr_next = ptr_reg + ADDR_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  // Storage: one register per live entry
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      if (gi >= N || (ZERO_REG != 0 && gi == 0)) begin : g_zero
        assign mem[gi] = '0;
      end else begin : g_live
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
        logic [WIDTH-1:0] q_reg;
        logic             wen;
        logic [WIDTH-1:0] wdata;

        // Ascending scan: a later (higher-index) port overrides earlier ones.
        always_comb begin
          wen   = 1'b0;
          wdata = q_reg;
          for (int j = 0; j < NW; j++) begin
            if (idle && W_en[j] && W_addr[j*ADDR_W +: ADDR_W] == IDX) begin
              wen   = 1'b1;
              wdata = W_data[j*WIDTH +: WIDTH];
            end
          end
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            q_reg <= '0;
          end else if (busy && ptr_reg == IDX) begin
            q_reg <= '0;
          end else if (wen) begin
            q_reg <= wdata;
          end
        end

        assign mem[gi] = q_reg;
      end
    end
  endgenerate

  // Read ports
  generate
    for (gi = 0; gi < NR; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [WIDTH-1:0]  rd_val;
      logic [WIDTH-1:0]  data_reg;
      logic              valid_reg;

      assign ra = R_addr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        rd_val = '0;
        if ({1'b0, ra} < N_EXT && !(ZERO_REG != 0 && ra == '0)) begin
          rd_val = mem[ra];
          // Forward the winning same-cycle write. Writes only land in IDLE,
          // which is also the only state in which reads are accepted.
          if (BYPASS != 0) begin
            for (int j = 0; j < NW; j++) begin
              if (W_en[j] && W_addr[j*ADDR_W +: ADDR_W] == ra) begin
                rd_val = W_data[j*WIDTH +: WIDTH];
              end
            end
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg  <= '0;
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= R_en[gi] && idle;
          if (R_en[gi] && idle) begin
            data_reg <= rd_val;
          end
        end
      end

      assign R_data[gi*WIDTH +: WIDTH] = data_reg;
      assign R_valid[gi]               = valid_reg;
    end
  endgenerate

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file, the successor to the single-port regfile. It provides NR registered read ports and NW write ports, with optional write-to-read bypass and an optional hard-wired zero entry. A sequenced bulk-clear engine lets software zero the array without a reset. It sits in datapath characterisation blocks as the configurable storage primitive.

Parameters:
WIDTH, 32, data bits per entry
N, 32, number of entries; ADDR_W = max(1, $clog2(N))
NR, 2, number of read ports (>=1)
NW, 2, number of write ports (>=1)
BYPASS, 1, 1: a same-cycle write is forwarded to the read; 0: the read returns the pre-write contents
ZERO_REG, 0, 1: entry 0 always reads 0 and ignores writes

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
R_addr  input  NR*ADDR_W  read addresses; port i uses slice [i*ADDR_W +: ADDR_W]
R_en  input  NR  per-port read enable
R_data  output  NR*WIDTH  registered read data; port i uses slice [i*WIDTH +: WIDTH]
R_valid  output  NR  high for one cycle when R_data[i] was updated by a read
W_addr  input  NW*ADDR_W  write addresses
W_en  input  NW  per-port write enable
W_data  input  NW*WIDTH  write data
clear  input  1  single-cycle request to zero all entries
busy  output  1  high while a clear is in progress

Behaviour:
- Reset (async assert): all entries = 0, R_data = 0, R_valid = 0, busy = 0, FSM = IDLE, clear pointer = 0. Reset has priority over everything, including mid-clear.
- Write: at the edge where W_en[j]=1, entry W_addr[j] takes W_data[j].
  - An address >= N is dropped.
  - With ZERO_REG=1, a write to address 0 is dropped.
  - If several ports write the same address in one cycle, the highest port index wins.
- Read: latency 1. At the edge where R_en[i]=1:
  - R_data[i] takes the entry contents and R_valid[i] goes to 1 for that cycle.
  - If R_en[i]=0, R_data[i] holds its last value and R_valid[i] = 0.
  - An address >= N returns 0. With ZERO_REG=1, address 0 returns 0.
- Bypass: with BYPASS=1, a read and an enabled write to the same valid address in the same cycle return the winning write data. With BYPASS=0, the read returns the old contents. Any number of read ports may read the same address.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clear=1 moves to CLEAR with ptr = 0. busy = 1 from the next cycle.
  - CLEAR: each cycle, entry ptr is set to 0 and ptr increments. When ptr == N-1 is cleared, the next state is IDLE and busy drops. CLEAR lasts exactly N cycles.
  - During CLEAR: W_en is ignored (writes are dropped), R_en is ignored (R_valid = 0 and R_data holds), and clear is ignored.
  - clear asserted together with W_en in IDLE: the writes in that cycle complete, then clearing begins.
- Widths: no arithmetic on data. ptr is ADDR_W bits and does not wrap past N-1.

Test Plan:
- Reset, write 0xDEADBEEF to addr 5 via W port 0, read addr 5 on R port 1 the next cycle -> R_data[1] = 0xDEADBEEF and R_valid[1] = 1 one edge later; R_data[0] stays 0 with R_valid[0] = 0.
- Same cycle: W0 writes 0x11 and W1 writes 0x22 to addr 3, with R0 reading addr 3 -> with BYPASS=1, R_data[0] = 0x22; a later read gives 0x22. With BYPASS=0, the first read gives the prior value (0 after reset).
- ZERO_REG=1: write 0xFFFF to addr 0, then read addr 0 -> 0. Read addr N (out of range) -> 0.
- Fill all N entries with their index, pulse clear, and attempt a write of 0xAA to addr 7 while busy:
  - busy is high for exactly N cycles.
  - Reads issued while busy give R_valid = 0.
  - After busy falls, every entry reads 0, including addr 7.
- Assert rst asynchronously mid-clear (ptr = N/2) -> busy, R_data and R_valid drop immediately. After release, all entries read 0 and a new write/read works normally.
- Hold R_en[0]=0 for 3 cycles after a read of 0x5A -> R_data[0] stays 0x5A and R_valid[0] = 0 throughout.
